bb_game_engine: RTL and testbench

Parametrised baseball game engine, successor to the fixed 3-inning scorer. Consumes one action code per accepted handshake. Tracks inning, half, outs, bases and both scores internally, so the stimulus needs no inning or half inputs. Applies end-of-game rules: home team leading after the top of the final inning, and walk-off. Reports the final score once per game, then rearms for the next game.

---
 rtl/bb_pkg.sv | 34 +++
 rtl/bb_play_resolve.sv | 83 ++++++++
 rtl/bb_game_engine.sv | 151 +++++++++++++++
 tb/tb_bb_game_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_pkg.sv
// bb_pkg: shared types for the baseball game engine.
//   action_e : play codes carried on the 3-bit action input
//   result_e : final result encoding reported with out_valid
//   state_e  : engine FSM states
//   base_count() : number of occupied bases
package bb_pkg;

    typedef enum logic [2:0] {
        WALK   = 3'd0,
        H1     = 3'd1,
        H2     = 3'd2,
        H3     = 3'd3,
        HR     = 3'd4,
        BUNT   = 3'd5,
        GROUND = 3'd6,
        FLY    = 3'd7
    } action_e;

    typedef enum logic [1:0] {
        RES_A    = 2'd0,
        RES_B    = 2'd1,
        RES_DRAW = 2'd2
    } result_e;

    typedef enum logic {
        S_PLAY   = 1'b0,
        S_REPORT = 1'b1
    } state_e;

    function automatic logic [2:0] base_count(input logic [2:0] b);
        return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]};
    endfunction

endpackage

// File: rtl/bb_play_resolve.sv
// bb_play_resolve: combinational resolution of one play.
// Ports:
//   action     in  3  play code (bb_pkg::action_e)
//   bases      in  3  occupancy before the play (bit0 = 1st)
//   outs       in  2  outs before the play
//   next_bases out 3  occupancy after the play (before any half-inning clear)
//   runs       out 3  runs scored by the play, 0..4
//   outs_add   out 2  outs recorded by the play, 0..2
// Parameter OUTS_PER_HALF selects the two-out running rules.
module bb_play_resolve
    import bb_pkg::*;
#(
    parameter int OUTS_PER_HALF = 3
) (
    input  logic [2:0] action,
    input  logic [2:0] bases,
    input  logic [1:0] outs,
    output logic [2:0] next_bases,
    output logic [2:0] runs,
    output logic [1:0] outs_add
);

    // With the final out pending, runners go on contact.
    logic last_out;
    assign last_out = (int'(outs) == OUTS_PER_HALF - 1);

    always_comb begin
        next_bases = bases;
        runs       = 3'd0;
        outs_add   = 2'd0;
        case (action_e'(action))
            WALK: begin
                // Only runners forced by the chain behind them move.
                next_bases = {bases[2] | (bases[1] & bases[0]), bases[1] | bases[0], 1'b1};
                runs       = {2'b00, &bases};
            end
            H1: begin
                if (last_out) begin
                    next_bases = {bases[0], 2'b01};
                    runs       = base_count(bases & 3'b110);
                end else begin
                    next_bases = {bases[1:0], 1'b1};
                    runs       = {2'b00, bases[2]};
                end
            end
            H2: begin
                if (last_out) begin
                    next_bases = 3'b010;
                    runs       = base_count(bases);
                end else begin
                    next_bases = {bases[0], 2'b10};
                    runs       = base_count(bases & 3'b110);
                end
            end
            H3: begin
                next_bases = 3'b100;
                runs       = base_count(bases);
            end
            HR: begin
                next_bases = 3'b000;
                runs       = base_count(bases) + 3'd1;
            end
            BUNT: begin
                next_bases = {bases[1:0], 1'b0};
                runs       = {2'b00, bases[2]};
                outs_add   = 2'd1;
            end
            GROUND: begin
                // Runner on 1st is doubled off; lead runners still move up.
                next_bases = {bases[1], 2'b00};
                runs       = {2'b00, bases[2]};
                outs_add   = 2'd1 + {1'b0, bases[0]};
            end
            FLY: begin
                next_bases = {1'b0, bases[1:0]};
                runs       = {2'b00, bases[2]};
                outs_add   = 2'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bb_game_engine.sv
// bb_game_engine: baseball game engine, one play per accepted action.
// Tracks inning/half/outs/bases/scores, applies end-of-game rules and
// reports the final score for one cycle before rearming.
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/action : action handshake (in_ready low in REPORT)
//   out_valid                : one-cycle final-result strobe
//   score_A/score_B/result   : final scores and result, zero unless out_valid
//   cur_inning/cur_half/outs/bases : live game status
// Optional: define BB_MERCY_EN to end games on a MERCY_RUNS lead at the end
// of any half from inning MERCY_INNING on.
module bb_game_engine
    import bb_pkg::*;
#(
    parameter int INNINGS       = 3,
    parameter int OUTS_PER_HALF = 3,
    parameter int SCORE_W       = 8,
    parameter int MERCY_RUNS    = 10,
    parameter int MERCY_INNING  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         action,
    output logic               out_valid,
    output logic [SCORE_W-1:0] score_A,
    output logic [SCORE_W-1:0] score_B,
    output logic [1:0]         result,
    output logic [3:0]         cur_inning,
    output logic               cur_half,
    output logic [1:0]         outs,
    output logic [2:0]         bases
);

    if (INNINGS < 1 || INNINGS > 15 || OUTS_PER_HALF < 1 || OUTS_PER_HALF > 3 ||
        SCORE_W < 1 || MERCY_RUNS < 1 || MERCY_INNING < 1) begin : g_bad_cfg
        $error("bb_game_engine: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [3:0]         inning_q;
    logic               half_q;
    logic [1:0]         outs_q;
    logic [2:0]         bases_q;
    logic [SCORE_W-1:0] score_a_q, score_b_q, score_a_d, score_b_d;
    logic [2:0]         play_bases, play_runs, runs_eff, outs_total;
    logic [1:0]         play_outs;
    logic               accept, half_end, final_inning;
    logic               walk_off, top_final, bot_final, mercy, game_end;
    result_e            cmp_res;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [2:0] r);
        logic [SCORE_W+2:0] sum;
        sum = {3'b000, s} + {{SCORE_W{1'b0}}, r};
        return (|sum[SCORE_W+2:SCORE_W]) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    bb_play_resolve #(.OUTS_PER_HALF(OUTS_PER_HALF)) u_resolve (
        .action     (action),
        .bases      (bases_q),
        .outs       (outs_q),
        .next_bases (play_bases),
        .runs       (play_runs),
        .outs_add   (play_outs)
    );

    assign accept     = in_valid & in_ready;
    assign outs_total = {1'b0, outs_q} + {1'b0, play_outs};
    assign half_end   = int'(outs_total) >= OUTS_PER_HALF;
    // A play that ends the half scores nothing.
    assign runs_eff   = half_end ? 3'd0 : play_runs;
    assign score_a_d  = half_q ? score_a_q : sat_add(score_a_q, runs_eff);
    assign score_b_d  = half_q ? sat_add(score_b_q, runs_eff) : score_b_q;

    // Every end rule has the same effect (report, result by comparison), so
    // their priority only matters for naming; they are simply OR-ed.
    assign final_inning = int'(inning_q) == INNINGS;
    assign walk_off     = half_q & final_inning & (score_b_d > score_a_d);
    assign top_final    = half_end & ~half_q & final_inning & (score_b_d > score_a_d);
    assign bot_final    = half_end & half_q & final_inning;
`ifdef BB_MERCY_EN
    logic [SCORE_W-1:0] lead;
    assign lead  = (score_a_d >= score_b_d) ? score_a_d - score_b_d : score_b_d - score_a_d;
    assign mercy = half_end & (int'(inning_q) >= MERCY_INNING) & (int'(lead) >= MERCY_RUNS);
`else
    assign mercy = 1'b0;
`endif
    assign game_end = walk_off | mercy | top_final | bot_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_PLAY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PLAY:   if (accept && game_end) state_d = S_REPORT;
            S_REPORT: state_d = S_PLAY;
            default:  state_d = S_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inning_q  <= 4'd1;
            half_q    <= 1'b0;
            outs_q    <= 2'd0;
            bases_q   <= 3'd0;
            score_a_q <= '0;
            score_b_q <= '0;
        end else if (state_q == S_REPORT) begin
            inning_q  <= 4'd1;
            half_q    <= 1'b0;
            outs_q    <= 2'd0;
            bases_q   <= 3'd0;
            score_a_q <= '0;
            score_b_q <= '0;
        end else if (accept) begin
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            if (half_end) begin
                outs_q  <= 2'd0;
                bases_q <= 3'd0;
                // On the game-ending out the inning/half freeze for the report.
                if (!game_end) begin
                    half_q <= ~half_q;
                    if (half_q) inning_q <= inning_q + 4'd1;
                end
            end else begin
                outs_q  <= outs_total[1:0];
                bases_q <= play_bases;
            end
        end
    end

    assign cmp_res    = (score_a_q > score_b_q) ? RES_A :
                        (score_b_q > score_a_q) ? RES_B : RES_DRAW;
    assign in_ready   = (state_q == S_PLAY);
    assign out_valid  = (state_q == S_REPORT);
    assign score_A    = out_valid ? score_a_q : '0;
    assign score_B    = out_valid ? score_b_q : '0;
    assign result     = out_valid ? cmp_res : RES_A;
    assign cur_inning = inning_q;
    assign cur_half   = half_q;
    assign outs       = outs_q;
    assign bases      = bases_q;

endmodule

// File: tb/tb_bb_game_engine.sv
`timescale 1ns/1ps
module tb_bb_game_engine;

    localparam int INN = 3, OPH = 3, MR = 10, MI = 2;
    localparam int DMAX = 255, SMAX = 7;
    localparam int A_WALK = 0, A_H1 = 1, A_H2 = 2, A_H3 = 3, A_HR = 4,
                   A_BUNT = 5, A_GROUND = 6, A_FLY = 7;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [2:0] action = 3'd0;

    logic       d_ready, d_valid, d_half, s_ready, s_valid, s_half;
    logic [7:0] d_sa, d_sb;
    logic [2:0] s_sa, s_sb, d_bases, s_bases;
    logic [1:0] d_res, s_res, d_outs, s_outs;
    logic [3:0] d_inn, s_inn;

    always #5 clk = ~clk;

    bb_game_engine u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_ready), .action(action),
        .out_valid(d_valid), .score_A(d_sa), .score_B(d_sb), .result(d_res),
        .cur_inning(d_inn), .cur_half(d_half), .outs(d_outs), .bases(d_bases)
    );

    bb_game_engine #(.SCORE_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready), .action(action),
        .out_valid(s_valid), .score_A(s_sa), .score_B(s_sb), .result(s_res),
        .cur_inning(s_inn), .cur_half(s_half), .outs(s_outs), .bases(s_bases)
    );

    // Game as a referee would keep it: occ[k] = runner standing on base k.
    typedef struct {
        int       inning;
        int       half;
        int       outs;
        bit [3:1] occ;
        int       a;
        int       b;
        bit       rep;
        int       res;
    } gs_t;

    gs_t md, ms;
    int  total = 0, bad = 0;

    function automatic gs_t fresh();
        gs_t s;
        s.inning = 1; s.half = 0; s.outs = 0; s.occ = '0;
        s.a = 0; s.b = 0; s.rep = 0; s.res = 0;
        return s;
    endfunction

    function automatic gs_t step(gs_t s, bit v, int act, int smax);
        bit [3:1] occ;
        int r, o, n, batter;
        bit last, hend, over;
        if (s.rep) return fresh();
        if (!v) return s;
        occ = s.occ; r = 0; o = 0; n = 0; batter = 0;
        last = (s.outs == OPH - 1);
        case (act)
            A_WALK: begin
                if (occ[1]) begin
                    if (occ[2]) begin
                        if (occ[3]) r = 1;
                        occ[3] = 1;
                    end
                    occ[2] = 1;
                end
                occ[1] = 1;
            end
            A_H1: begin n = last ? 2 : 1; batter = 1; end
            A_H2: begin
                if (last) begin r = $countones(occ); occ = '0; end
                else n = 2;
                batter = 2;
            end
            A_H3:     begin r = $countones(occ); occ = '0; batter = 3; end
            A_HR:     begin r = $countones(occ) + 1; occ = '0; end
            A_BUNT:   begin o = 1; n = 1; end
            A_GROUND: begin o = 1 + int'(occ[1]); occ[1] = 0; n = 1; end
            default:  begin o = 1; if (occ[3]) begin r = 1; occ[3] = 0; end end
        endcase
        // runners move n bases, lead runner first so nobody is overtaken
        for (int k = 3; k >= 1; k--) begin
            if (n > 0 && occ[k]) begin
                occ[k] = 0;
                if (k + n > 3) r++;
                else occ[k + n] = 1;
            end
        end
        if (batter > 0) occ[batter] = 1;
        hend = (s.outs + o >= OPH);
        if (hend) r = 0;
        if (s.half == 0) s.a = (s.a + r > smax) ? smax : s.a + r;
        else             s.b = (s.b + r > smax) ? smax : s.b + r;
        over = (s.half == 1 && s.inning == INN && s.b > s.a);
`ifdef BB_MERCY_EN
        if (hend && s.inning >= MI && (s.a - s.b >= MR || s.b - s.a >= MR)) over = 1;
`endif
        if (hend && s.inning == INN && (s.half == 1 || s.b > s.a)) over = 1;
        if (hend) begin s.outs = 0; s.occ = '0; end
        else begin s.outs = s.outs + o; s.occ = occ; end
        if (over) begin
            s.rep = 1;
            s.res = (s.a > s.b) ? 0 : (s.b > s.a) ? 1 : 2;
        end else if (hend) begin
            if (s.half == 1) s.inning++;
            s.half = 1 - s.half;
        end
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_inst(input string t, input gs_t m, input int rdy, input int vld,
                            input int sa, input int sb, input int res, input int inn,
                            input int hf, input int o, input int bs);
        chk({t, "_ready"},  rdy, int'(!m.rep));
        chk({t, "_valid"},  vld, int'(m.rep));
        chk({t, "_scoreA"}, sa,  m.rep ? m.a : 0);
        chk({t, "_scoreB"}, sb,  m.rep ? m.b : 0);
        chk({t, "_result"}, res, m.rep ? m.res : 0);
        chk({t, "_inning"}, inn, m.inning);
        chk({t, "_half"},   hf,  m.half);
        chk({t, "_outs"},   o,   m.outs);
        chk({t, "_bases"},  bs,  int'(m.occ));
    endtask

    // Single compare process: every cycle, both engines against the model.
    always @(negedge clk) begin
        chk_inst("dut", md, int'(d_ready), int'(d_valid), int'(d_sa), int'(d_sb), int'(d_res),
                 int'(d_inn), int'(d_half), int'(d_outs), int'(d_bases));
        chk_inst("sat", ms, int'(s_ready), int'(s_valid), int'(s_sa), int'(s_sb), int'(s_res),
                 int'(s_inn), int'(s_half), int'(s_outs), int'(s_bases));
    end

    task automatic cyc(input bit v, input int a);
        in_valid = v;
        action   = 3'(a);
        @(posedge clk);
        md = step(md, v, a, DMAX);
        ms = step(ms, v, a, SMAX);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        md = fresh();
        ms = fresh();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic finish_game(input string name);
        int n;
        n = 0;
        while (!d_valid && n < 100) begin
            cyc(1'b1, A_FLY);
            n++;
        end
        chk({name, "_reached"}, int'(d_valid), 1);
    endtask

    initial begin
        md = fresh();
        ms = fresh();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", int'(d_ready), 1);
        chk("rst_valid", int'(d_valid), 0);
        chk("rst_inning", int'(d_inn), 1);

        // HR in top 1, then nothing but flies: guest wins 1-0.
        cyc(1'b1, A_HR);
        repeat (18) cyc(1'b1, A_FLY);
        chk("t1_valid", int'(d_valid), 1);
        chk("t1_busy", int'(d_ready), 0);
        chk("t1_scoreA", int'(d_sa), 1);
        chk("t1_scoreB", int'(d_sb), 0);
        chk("t1_result", int'(d_res), 0);
        cyc(1'b1, A_FLY);   // offered during REPORT, not taken
        chk("t1_rearm_ready", int'(d_ready), 1);
        chk("t1_rearm_outs", int'(d_outs), 0);

        // Home leads 2-0 after top 3: bottom 3 is skipped.
        repeat (3) cyc(1'b1, A_FLY);
        cyc(1'b1, A_HR);
        cyc(1'b1, A_HR);
        repeat (12) cyc(1'b1, A_FLY);
        chk("t2_valid", int'(d_valid), 1);
        chk("t2_scoreB", int'(d_sb), 2);
        chk("t2_result", int'(d_res), 1);
        cyc(1'b1, A_FLY);

        // Walk-off grand slam in bottom 3 down 0-1.
        cyc(1'b1, A_HR);
        repeat (15) cyc(1'b1, A_FLY);
        repeat (3) cyc(1'b1, A_WALK);
        cyc(1'b1, A_HR);
        chk("t3_valid", int'(d_valid), 1);
        chk("t3_scoreA", int'(d_sa), 1);
        chk("t3_scoreB", int'(d_sb), 4);
        chk("t3_result", int'(d_res), 1);
        chk("t3_sat_scoreB", int'(s_sb), 4);
        cyc(1'b1, A_FLY);

        // Two-out double play ends the half; two-out single scores from 2nd.
        cyc(1'b1, A_FLY);
        cyc(1'b1, A_FLY);
        cyc(1'b1, A_WALK);
        cyc(1'b1, A_GROUND);
        chk("t4_half", int'(d_half), 1);
        chk("t4_outs", int'(d_outs), 0);
        chk("t4_bases", int'(d_bases), 0);
        cyc(1'b1, A_FLY);
        cyc(1'b1, A_H2);
        cyc(1'b1, A_WALK);
        cyc(1'b1, A_BUNT);
        chk("t4_outs2", int'(d_outs), 2);
        chk("t4_bases23", int'(d_bases), 6);
        cyc(1'b1, A_H1);
        chk("t4_bases_single", int'(d_bases), 1);
        finish_game("t4");
        chk("t4_scoreB", int'(d_sb), 2);
        chk("t4_result", int'(d_res), 1);
        cyc(1'b1, A_FLY);

        // Eight runs in top 1: 3-bit score pins at 7.
        repeat (3) cyc(1'b1, A_WALK);
        cyc(1'b1, A_HR);
        repeat (3) cyc(1'b1, A_WALK);
        cyc(1'b1, A_HR);
        finish_game("t5");
        chk("t5_dut_scoreA", int'(d_sa), 8);
        chk("t5_sat_scoreA", int'(s_sa), 7);
        chk("t5_sat_result", int'(s_res), 0);
        cyc(1'b1, A_FLY);

        // Random play, with one mid-game reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)));
        end

`ifdef BB_MERCY_EN
        do_reset();
        repeat (6) cyc(1'b1, A_FLY);
        repeat (2) begin
            repeat (3) cyc(1'b1, A_WALK);
            cyc(1'b1, A_HR);
        end
        cyc(1'b1, A_H2);
        cyc(1'b1, A_HR);
        repeat (3) cyc(1'b1, A_FLY);
        chk("m_valid", int'(d_valid), 1);
        chk("m_busy", int'(d_ready), 0);
        chk("m_scoreA", int'(d_sa), 10);
        chk("m_result", int'(d_res), 0);
        cyc(1'b1, A_HR);
        chk("m_rearm_bases", int'(d_bases), 0);
        cyc(1'b0, 0);
`endif

        in_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
